voice_bank: RTL and testbench
=============================

# voice_bank

Parametrised multi-voice oscillator bank that supersedes the single-voice channel. It holds NUM_VOICES independent voice register sets behind a byte-wide synchronous bus and steps every voice once per SampleTick using one shared, time-multiplexed waveform/level datapath. It sums the results into a single saturated mix sample for the output stage.

## Interface
- WAVE_DEPTH, 8: output and per-voice waveform width, legal range 4..16.
- NUM_VOICES, 4: voice count, legal range 1..16.
- BASE_ADDR, 0: first bus address of the block.
- Clock  in  1  single system clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
- SampleTick  in  1  one-cycle pulse that starts a mix pass.
- BusAddress  in  16  register address.
- BusWriteData  in  8  write data.
- BusWrite  in  1  write strobe, one cycle per write.
- BusRead  in  1  read strobe, one cycle per read.
- BusReadData  out  8  read data.
- BusReadValid  out  1  read data qualifier.
- Mix  out  WAVE_DEPTH  unsigned mix sample; midscale is silence.
- MixValid  out  1  one-cycle pulse when Mix updates.
- Busy  out  1  high while a mix pass is in progress.

## Operation
- Register map: voice v, offset r is at BASE_ADDR+8*v+r.
  - r0 control: bit0 gate, bits2:1 wavetype, bit3 phase-clear (write-1 strobe, reads 0).
  - r1/r2: increment low/high byte.
  - r3: pulsewidth.
  - r4: level.
  - r5: status, read-only; bit0 = gate.
  - r6, r7: reserved; read 0, writes ignored.
- Global register at BASE_ADDR+8*NUM_VOICES:
  - bit0 enable.
  - bit1 overrun, sticky; writing 1 clears it.
  - bits7:4 read NUM_VOICES-1.
- Phase: one 16-bit accumulator per voice. W = phase[15:16-WAVE_DEPTH].
- Wavetypes:
  - 0 saw: W.
  - 1 triangle: phase[15] ? ~(phase[14:..]<<1) : (phase[14:..]<<1), truncated to WAVE_DEPTH.
  - 2 pulse: phase[15:8] < pulsewidth ? all-ones : 0.
  - 3 silence: midscale.
- Per-voice step:
  - s = wave - 2^(WAVE_DEPTH-1), signed WAVE_DEPTH+1 bits.
  - c = (s*level) >>> 8, arithmetic, floor rounding.
  - If gate=0, c=0.
  - The wave is computed from the current phase; then phase += incr (mod 2^16) only when gate=1.
  - phase-clear sets phase to 0 and takes precedence over the increment in the same cycle.
- Accumulator: signed, WAVE_DEPTH+1+ceil(log2 NUM_VOICES) bits.
- Final mix: sum saturated to [-2^(WAVE_DEPTH-1), 2^(WAVE_DEPTH-1)-1], then offset by +2^(WAVE_DEPTH-1) to form the unsigned Mix.
- FSM states: IDLE, RUN, OUT.
  - IDLE: waits for SampleTick. If the tick arrives with enable=1, clear the accumulator, set voice index 0, go to RUN. If enable=0, the tick is ignored and does not count as overrun.
  - RUN: processes one voice per cycle; after voice NUM_VOICES-1, go to OUT.
  - OUT: latch Mix, pulse MixValid, return to IDLE.
- A SampleTick in RUN or OUT is dropped and sets overrun. The pass in progress is unaffected.
- Bus rules:
  - A write to a voice's registers in the same cycle that voice is processed: the datapath uses the pre-write value, and the new value applies from the next pass.
  - A bus write to phase-clear during RUN applies immediately.
  - BusWrite and BusRead high together: the write is performed and the read is ignored.
  - An address outside the block: writes ignored; reads give BusReadValid=0, BusReadData=0.

## Timing
- Reset values:
  - Mix = 2^(WAVE_DEPTH-1).
  - MixValid, Busy, BusReadValid = 0.
  - BusReadData = 0.
  - All voice registers, phases, enable and overrun = 0; FSM in IDLE.
- Reset asserted mid-pass aborts the pass with no MixValid. Operation resumes on the first SampleTick after release.
- Busy rises on the cycle after an accepted SampleTick and stays high for NUM_VOICES+1 cycles (RUN plus OUT).
- MixValid is high in the cycle Mix updates, NUM_VOICES+1 cycles after the tick edge. Mix holds between passes.
- Minimum accepted tick spacing: NUM_VOICES+2 cycles.
- Register writes are visible on the following clock.
- Reads: BusReadData and BusReadValid are registered and valid for exactly one cycle after the BusRead cycle. BusReadData returns 0 when no read is in progress.

## Test plan
- Reset: drive Reset low mid-operation -> Mix=0x80, Busy=0, all register reads 0 after release (WAVE_DEPTH=8, NUM_VOICES=4).
- Saw voice: voice0 incr=0x0100, level=0xFF, wavetype=0, gate=1, enable=1, then ticks spaced 8 cycles apart.
  - Successive Mix values: 0x00, 0x01, 0x02.
  - MixValid arrives exactly 5 cycles after each tick.
- Saturation: all 4 voices pulse, pulsewidth=0xFF, level=0xFF, phase 0.
  - Raw sum = 504 -> Mix=0xFF.
  - With all gates cleared -> Mix=0x80.
- Overrun: second tick 2 cycles after the first.
  - Only one MixValid.
  - Global read = 0x33.
  - Writing 0x03 clears overrun; global read = 0x31.
- Bus readback: write 0x34 to addr 17 and 0x12 to addr 18.
  - Read addr 17 gives 0x34 with BusReadValid one cycle later; addr 18 gives 0x12.
  - Read addr 40 gives BusReadValid=0.
- Phase-clear and enable: write control=0x09 during RUN -> the voice's next-pass wave is computed from phase 0. With enable=0, ticks produce no Busy and no MixValid.

Source files
------------

// File: rtl/voice_bank.sv
// voice_bank: multi-voice oscillator bank. NUM_VOICES voice register sets sit behind
// a byte-wide bus. One shared waveform/level datapath steps each voice once per
// SampleTick. The saturated sum is presented as an unsigned Mix sample, with
// midscale meaning silence.
// Ports:
//   Clock, Reset           rising-edge clock, asynchronous active-low reset
//   SampleTick             one-cycle pulse that starts a mix pass
//   BusAddress/WriteData   register address and write byte
//   BusWrite/BusRead       one-cycle access strobes (write wins when both are high)
//   BusReadData/Valid      registered read response, one cycle after BusRead
//   Mix/MixValid           unsigned mix sample and its one-cycle update pulse
//   Busy                   high while a mix pass is in progress
module voice_bank #(
  parameter int unsigned WAVE_DEPTH = 8,
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SampleTick,
  input  logic [15:0]           BusAddress,
  input  logic [7:0]            BusWriteData,
  input  logic                  BusWrite,
  input  logic                  BusRead,
  output logic [7:0]            BusReadData,
  output logic                  BusReadValid,
  output logic [WAVE_DEPTH-1:0] Mix,
  output logic                  MixValid,
  output logic                  Busy
);

  localparam int unsigned VIDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned ACC_W      = WAVE_DEPTH + 1 + $clog2(NUM_VOICES);
  localparam int unsigned PROD_W     = WAVE_DEPTH + 10;
  localparam int unsigned VOICE_SPAN = 8 * NUM_VOICES;
  localparam logic [VIDX_W-1:0]     LAST_VOICE = VIDX_W'(NUM_VOICES - 1);
  localparam logic [WAVE_DEPTH-1:0] MID        = {1'b1, {(WAVE_DEPTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (WAVE_DEPTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (WAVE_DEPTH - 1)));

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  state_t                   state, state_next;
  logic [VIDX_W-1:0]        vidx, vidx_next;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic [WAVE_DEPTH-1:0]    mix_next, mix_sat;
  logic                     mix_valid_next, busy_next;
  logic                     enable, overrun;

  logic       v_gate  [NUM_VOICES];
  logic [1:0] v_wave  [NUM_VOICES];
  logic [15:0] v_incr [NUM_VOICES];
  logic [15:0] v_phase[NUM_VOICES];
  logic [7:0] v_pw    [NUM_VOICES];
  logic [7:0] v_level [NUM_VOICES];

  // Address decode relative to BASE_ADDR; bit 16 flags addresses below the block.
  logic [16:0] rel;
  logic        in_voice, in_global, wr_voice, wr_global;
  logic [3:0]  sel_voice;
  logic [2:0]  sel_reg;

  assign rel       = {1'b0, BusAddress} - 17'(BASE_ADDR);
  assign in_voice  = !rel[16] && (rel < 17'(VOICE_SPAN));
  assign in_global = (rel == 17'(VOICE_SPAN));
  assign sel_voice = rel[6:3];
  assign sel_reg   = rel[2:0];
  assign wr_voice  = BusWrite && in_voice;
  assign wr_global = BusWrite && in_global;

  // Select the voice currently owned by the shared datapath.
  logic        cur_gate;
  logic [1:0]  cur_wave;
  logic [15:0] cur_phase;
  logic [7:0]  cur_pw, cur_level;

  always_comb begin
    cur_gate  = 1'b0;
    cur_wave  = 2'd0;
    cur_phase = 16'd0;
    cur_pw    = 8'd0;
    cur_level = 8'd0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (vidx == VIDX_W'(v)) begin
        cur_gate  = v_gate[v];
        cur_wave  = v_wave[v];
        cur_phase = v_phase[v];
        cur_pw    = v_pw[v];
        cur_level = v_level[v];
      end
    end
  end

  // Waveform generation from the current phase.
  logic [WAVE_DEPTH-1:0] wave, tri_ramp;

  always_comb begin
    tri_ramp = {cur_phase[14 -: (WAVE_DEPTH - 1)], 1'b0};
    case (cur_wave)
      2'd0:    wave = cur_phase[15 -: WAVE_DEPTH];
      2'd1:    wave = cur_phase[15] ? ~tri_ramp : tri_ramp;
      2'd2:    wave = (cur_phase[15:8] < cur_pw) ? '1 : '0;
      default: wave = MID;
    endcase
  end

  // Remove midscale offset (wave - MID == sign-extended wave with MSB inverted), then scale by level.
  logic signed [WAVE_DEPTH:0]  sample, contrib;
  logic signed [PROD_W-1:0]    prod;
  logic                        unused_bits;

  assign sample      = {~wave[WAVE_DEPTH-1], ~wave[WAVE_DEPTH-1], wave[WAVE_DEPTH-2:0]};
  assign prod        = PROD_W'(sample) * PROD_W'($signed({1'b0, cur_level}));
  assign contrib     = cur_gate ? prod[WAVE_DEPTH+8:8] : '0;
  assign unused_bits = ^{prod[7:0], prod[PROD_W-1], cur_phase[7:0]};

  // Saturate the accumulator and convert to offset binary.
  always_comb begin
    if (acc > SAT_HI)      mix_sat = '1;
    else if (acc < SAT_LO) mix_sat = '0;
    else                   mix_sat = {~acc[WAVE_DEPTH-1], acc[WAVE_DEPTH-2:0]};
  end

  // Pass sequencer: next state and registered-output next values.
  always_comb begin
    state_next     = state;
    vidx_next      = vidx;
    acc_next       = acc;
    mix_next       = Mix;
    mix_valid_next = 1'b0;
    case (state)
      IDLE: begin
        if (SampleTick && enable) begin
          state_next = RUN;
          vidx_next  = '0;
          acc_next   = '0;
        end
      end
      RUN: begin
        acc_next = acc + ACC_W'(contrib);
        if (vidx == LAST_VOICE) state_next = OUT;
        else                    vidx_next  = vidx + VIDX_W'(1);
      end
      OUT: begin
        mix_next       = mix_sat;
        mix_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      vidx     <= '0;
      acc      <= '0;
      Mix      <= MID;
      MixValid <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      state    <= state_next;
      vidx     <= vidx_next;
      acc      <= acc_next;
      Mix      <= mix_next;
      MixValid <= mix_valid_next;
      Busy     <= busy_next;
    end
  end

  // Global control: a tick outside IDLE is dropped and flagged; the flag wins over a clear.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      enable  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr_global) enable <= BusWriteData[0];
      if (SampleTick && (state != IDLE))      overrun <= 1'b1;
      else if (wr_global && BusWriteData[1])  overrun <= 1'b0;
    end
  end

  // Voice registers and phase accumulators; phase-clear beats the step increment.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        v_gate[v]  <= 1'b0;
        v_wave[v]  <= 2'd0;
        v_incr[v]  <= 16'd0;
        v_phase[v] <= 16'd0;
        v_pw[v]    <= 8'd0;
        v_level[v] <= 8'd0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_voice && (sel_voice == 4'(v))) begin
          case (sel_reg)
            3'd0: begin
              v_gate[v] <= BusWriteData[0];
              v_wave[v] <= BusWriteData[2:1];
            end
            3'd1:    v_incr[v][7:0]  <= BusWriteData;
            3'd2:    v_incr[v][15:8] <= BusWriteData;
            3'd3:    v_pw[v]         <= BusWriteData;
            3'd4:    v_level[v]      <= BusWriteData;
            default: ;
          endcase
        end
        if (wr_voice && (sel_voice == 4'(v)) && (sel_reg == 3'd0) && BusWriteData[3])
          v_phase[v] <= 16'd0;
        else if ((state == RUN) && (vidx == VIDX_W'(v)) && v_gate[v])
          v_phase[v] <= v_phase[v] + v_incr[v];
      end
    end
  end

  // Read mux; a simultaneous write suppresses the read.
  logic       rd_hit_c;
  logic [7:0] rd_byte_c;

  always_comb begin
    rd_hit_c  = 1'b0;
    rd_byte_c = 8'd0;
    if (BusRead && !BusWrite) begin
      if (in_global) begin
        rd_hit_c  = 1'b1;
        rd_byte_c = {4'(NUM_VOICES - 1), 2'b00, overrun, enable};
      end else if (in_voice) begin
        rd_hit_c = 1'b1;
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (sel_voice == 4'(v)) begin
            case (sel_reg)
              3'd0:    rd_byte_c = {5'd0, v_wave[v], v_gate[v]};
              3'd1:    rd_byte_c = v_incr[v][7:0];
              3'd2:    rd_byte_c = v_incr[v][15:8];
              3'd3:    rd_byte_c = v_pw[v];
              3'd4:    rd_byte_c = v_level[v];
              3'd5:    rd_byte_c = {7'd0, v_gate[v]};
              default: rd_byte_c = 8'd0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      BusReadData  <= 8'd0;
      BusReadValid <= 1'b0;
    end else begin
      BusReadData  <= rd_byte_c;
      BusReadValid <= rd_hit_c;
    end
  end

endmodule

// File: tb/tb_voice_bank.sv
// Directed bench for voice_bank (WAVE_DEPTH=8, NUM_VOICES=4, BASE_ADDR=0).
module tb_voice_bank;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        SampleTick;
  logic [15:0] BusAddress;
  logic [7:0]  BusWriteData;
  logic        BusWrite;
  logic        BusRead;
  logic [7:0]  BusReadData;
  logic        BusReadValid;
  logic [7:0]  Mix;
  logic        MixValid;
  logic        Busy;

  int errors = 0;
  int checks = 0;

  voice_bank #(.WAVE_DEPTH(8), .NUM_VOICES(4), .BASE_ADDR(0)) dut (
    .Clock(Clock), .Reset(Reset), .SampleTick(SampleTick),
    .BusAddress(BusAddress), .BusWriteData(BusWriteData),
    .BusWrite(BusWrite), .BusRead(BusRead),
    .BusReadData(BusReadData), .BusReadValid(BusReadValid),
    .Mix(Mix), .MixValid(MixValid), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    BusAddress   = a;
    BusWriteData = d;
    BusWrite     = 1'b1;
    cyc();
    BusWrite     = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic v);
    BusAddress = a;
    BusRead    = 1'b1;
    cyc();
    BusRead    = 1'b0;
    d = BusReadData;
    v = BusReadValid;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a,
                            input logic [7:0] exp_d, input logic exp_v);
    logic [7:0] d;
    logic       v;
    bus_read(a, d, v);
    check({tag, "_data"}, 16'(d), 16'(exp_d));
    check({tag, "_valid"}, 16'(v), 16'(exp_v));
  endtask

  // One full pass: latency from tick edge to MixValid, Busy length, and Mix value.
  task automatic run_pass(input string tag, input logic [7:0] exp_mix);
    int lat;
    int busy_n;
    lat    = 0;
    busy_n = 0;
    SampleTick = 1'b1;
    cyc();
    SampleTick = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (Busy) busy_n++;
      cyc();
      if (MixValid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, 16'(lat), 16'd5);
    check({tag, "_busy"}, 16'(busy_n), 16'd5);
    check({tag, "_mix"}, 16'(Mix), 16'(exp_mix));
    cyc();
    check({tag, "_mv_pulse"}, 16'(MixValid), 16'd0);
    cyc();
  endtask

  initial begin
    int mv_n;
    int busy_n;
    int lat;

    Reset        = 1'b0;
    SampleTick   = 1'b0;
    BusAddress   = 16'd0;
    BusWriteData = 8'd0;
    BusWrite     = 1'b0;
    BusRead      = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_mix", 16'(Mix), 16'h80);
    check("rst_busy", 16'(Busy), 16'd0);
    check("rst_mv", 16'(MixValid), 16'd0);
    check("rst_rv", 16'(BusReadValid), 16'd0);
    check("rst_rd", 16'(BusReadData), 16'd0);
    Reset = 1'b1;
    cyc();

    // Saw voice: incr 0x0100, full level, Mix steps 0x00, 0x01, 0x02.
    bus_write(16'd1, 8'h00);
    bus_write(16'd2, 8'h01);
    bus_write(16'd4, 8'hFF);
    bus_write(16'd0, 8'h01);
    bus_write(16'd32, 8'h01);
    run_pass("saw0", 8'h00);
    run_pass("saw1", 8'h01);
    run_pass("saw2", 8'h02);

    // Overrun: second tick two cycles after the first; phase 0x0300 gives Mix 0x03.
    SampleTick = 1'b1;
    cyc();
    SampleTick = 1'b0;
    cyc();
    SampleTick = 1'b1;
    cyc();
    SampleTick = 1'b0;
    mv_n = 0;
    repeat (12) begin
      if (MixValid) mv_n++;
      cyc();
    end
    check("ovr_mv_count", 16'(mv_n), 16'd1);
    check("ovr_mix", 16'(Mix), 16'h03);
    read_check("ovr_glob", 16'd32, 8'h33, 1'b1);
    bus_write(16'd32, 8'h03);
    read_check("ovr_clr", 16'd32, 8'h31, 1'b1);

    // Saturation: four full-width pulses at 126 each sum to 504.
    for (int v = 0; v < 4; v++) begin
      bus_write(16'(8 * v + 3), 8'hFF);
      bus_write(16'(8 * v + 4), 8'hFF);
      bus_write(16'(8 * v), 8'h0D);
    end
    run_pass("sat", 8'hFF);
    for (int v = 0; v < 4; v++) bus_write(16'(8 * v), 8'h04);
    run_pass("gates_off", 8'h80);

    // Bus readback and decode edges.
    bus_write(16'd17, 8'h34);
    bus_write(16'd18, 8'h12);
    read_check("rd17", 16'd17, 8'h34, 1'b1);
    check("rd17_after_valid", 16'(BusReadValid), 16'd1);
    cyc();
    check("rd_idle_valid", 16'(BusReadValid), 16'd0);
    check("rd_idle_data", 16'(BusReadData), 16'd0);
    read_check("rd18", 16'd18, 8'h12, 1'b1);
    read_check("rd40", 16'd40, 8'h00, 1'b0);
    read_check("rd_ctrl0", 16'd0, 8'h04, 1'b1);
    read_check("rd_stat0", 16'd5, 8'h00, 1'b1);
    read_check("rd_rsvd", 16'd6, 8'h00, 1'b1);
    BusAddress   = 16'd19;
    BusWriteData = 8'h5A;
    BusWrite     = 1'b1;
    BusRead      = 1'b1;
    cyc();
    BusWrite = 1'b0;
    BusRead  = 1'b0;
    check("wr_rd_both_valid", 16'(BusReadValid), 16'd0);
    read_check("rd19", 16'd19, 8'h5A, 1'b1);

    // Phase-clear during RUN: voice0 at phase 0x0100, saw, gated.
    bus_write(16'd0, 8'h01);
    read_check("rd_stat_gate", 16'd5, 8'h01, 1'b1);
    run_pass("pc_pre", 8'h01);
    SampleTick = 1'b1;
    cyc();
    SampleTick = 1'b0;
    cyc();
    bus_write(16'd0, 8'h09);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (MixValid) begin
        lat = n;
        break;
      end
    end
    check("pc_run_lat", 16'(lat), 16'd3);
    check("pc_run_mix", 16'(Mix), 16'h02);
    cyc();
    cyc();
    run_pass("pc_next", 8'h00);
    read_check("pc_ctrl_rd", 16'd0, 8'h01, 1'b1);

    // Enable off: ticks ignored, no overrun.
    bus_write(16'd32, 8'h00);
    SampleTick = 1'b1;
    cyc();
    SampleTick = 1'b0;
    mv_n   = 0;
    busy_n = 0;
    repeat (10) begin
      if (MixValid) mv_n++;
      if (Busy) busy_n++;
      cyc();
    end
    check("dis_mv", 16'(mv_n), 16'd0);
    check("dis_busy", 16'(busy_n), 16'd0);
    check("dis_mix_hold", 16'(Mix), 16'h00);
    read_check("dis_glob", 16'd32, 8'h30, 1'b1);

    // Reset mid-pass aborts with no MixValid.
    bus_write(16'd32, 8'h01);
    SampleTick = 1'b1;
    cyc();
    SampleTick = 1'b0;
    cyc();
    cyc();
    check("mid_busy_before", 16'(Busy), 16'd1);
    Reset = 1'b0;
    #1;
    check("mid_rst_mix", 16'(Mix), 16'h80);
    check("mid_rst_busy", 16'(Busy), 16'd0);
    cyc();
    Reset = 1'b1;
    mv_n = 0;
    repeat (8) begin
      if (MixValid) mv_n++;
      cyc();
    end
    check("mid_rst_no_mv", 16'(mv_n), 16'd0);
    read_check("post_rst_ctrl", 16'd0, 8'h00, 1'b1);
    read_check("post_rst_incr", 16'd17, 8'h00, 1'b1);
    read_check("post_rst_lvl", 16'd4, 8'h00, 1'b1);
    read_check("post_rst_glob", 16'd32, 8'h30, 1'b1);
    bus_write(16'd32, 8'h01);
    run_pass("post_rst_pass", 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
